// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the controller state encoding, opcode field layout and the NOP word.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_NOP  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_ALU  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_LOAD = 5'd2;
    localparam logic [OPC_W-1:0] OPC_STOR = 5'd3;
    localparam logic [OPC_W-1:0] OPC_BRCH = 5'd4;

    localparam logic [31:0] NOP_WORD = {OPC_NOP, 27'd0};

endpackage

// File: rtl/ram_sp_sinc.sv
// Synchronous RAM: one write port, one enabled read port.
// A read of the address being written returns the previous content.
module ram_sp_sinc #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clock) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memoria_instrucoes_carregavel.sv
// Run-time loadable instruction memory: valid/ready loader with auto-incrementing
// pointer, then 1-cycle registered fetch with stall hold and out-of-range fault.
module memoria_instrucoes_carregavel
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int PC_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(instr_mem_pkg::NOP_WORD)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_load_done,
    output logic              o_load_error,
    output logic              o_busy,
    input  logic              i_fetch_en,
    input  logic              i_stall,
    input  logic [PC_W-1:0]   i_endereco,
    output logic [DATA_W-1:0] o_instrucao,
    output logic              o_instr_valid,
    output logic              o_addr_fault
);

    localparam int AW = $clog2(DEPTH);

    state_t            r_state;
    logic [AW-1:0]     r_ptr;
    logic              r_loaded;
    logic              r_load_done;
    logic              r_load_error;
    logic              r_valid;
    logic              r_fault;
    logic              r_src_ram;

    logic              w_load_ready;
    logic              w_accept;
    logic              w_ptr_end;
    logic              w_in_range;
    logic              w_fetch_act;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_load_ready = (r_state == LOAD) & ~i_load_start;
    assign w_accept     = i_load_valid & w_load_ready;
    assign w_ptr_end    = (r_ptr == AW'(DEPTH - 1));
    assign w_in_range   = (i_endereco < PC_W'(DEPTH));
    // A load_start in RUN drops any fetch offered in the same cycle
    assign w_fetch_act  = (r_state == RUN) & r_loaded & ~i_load_start;
    assign w_re         = w_fetch_act & ~i_stall & i_fetch_en & w_in_range;

    ram_sp_sinc #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clock (i_clock),
        .i_we    (w_accept),
        .i_waddr (r_ptr),
        .i_wdata (i_load_data),
        .i_re    (w_re),
        .i_raddr (i_endereco[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_loaded     <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_src_ram    <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                IDLE, RUN: begin
                    if (i_load_start) begin
                        r_state      <= LOAD;
                        r_ptr        <= '0;
                        r_load_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (i_load_start) begin
                        r_ptr        <= '0;
                        r_load_error <= 1'b0;
                    end else if (w_accept) begin
                        r_ptr <= r_ptr + AW'(1);
                        if (i_load_last || w_ptr_end) begin
                            r_state     <= RUN;
                            r_load_done <= 1'b1;
                            r_loaded    <= 1'b1;
                        end
                        if (w_ptr_end && !i_load_last)
                            r_load_error <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // RAM read data is held by its own enable, so r_src_ram only picks the source
            if (!w_fetch_act) begin
                r_valid   <= 1'b0;
                r_fault   <= 1'b0;
                r_src_ram <= 1'b0;
            end else if (!i_stall) begin
                if (i_fetch_en) begin
                    r_valid   <= 1'b1;
                    r_fault   <= ~w_in_range;
                    r_src_ram <= w_in_range;
                end else begin
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                end
            end
        end
    end

    assign o_load_ready  = w_load_ready;
    assign o_load_done   = r_load_done;
    assign o_load_error  = r_load_error;
    assign o_busy        = (r_state == LOAD);
    assign o_instrucao   = r_src_ram ? w_rdata : NOP_WORD;
    assign o_instr_valid = r_valid;
    assign o_addr_fault  = r_fault;

endmodule

// File: tb/tb_memoria_instrucoes_carregavel.sv
// Self-checking bench: scoreboard of expected fetch results for a DEPTH=1024 instance,
// plus a DEPTH=8 instance for the overflow path.
module tb_memoria_instrucoes_carregavel;

    localparam int D = 1024;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic        v;
        logic        f;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        load_start = 0, load_valid = 0, load_last = 0;
    logic [31:0] load_data = '0;
    logic        load_ready, load_done, load_error, busy;
    logic        fetch_en = 0, stall = 0;
    logic [31:0] endereco = '0;
    logic [31:0] instrucao;
    logic        instr_valid, addr_fault;

    logic        s_load_start = 0, s_load_valid = 0, s_load_last = 0;
    logic [31:0] s_load_data = '0;
    logic        s_load_ready, s_load_done, s_load_error, s_busy;
    logic        s_fetch_en = 0, s_stall = 0;
    logic [31:0] s_endereco = '0;
    logic [31:0] s_instrucao;
    logic        s_instr_valid, s_addr_fault;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        sb_q[$];
    exp_t        last_e;
    logic [31:0] mdl [D];

    memoria_instrucoes_carregavel u_dut (
        .i_clock(clk), .i_reset(rst),
        .i_load_start(load_start), .i_load_valid(load_valid),
        .i_load_data(load_data), .i_load_last(load_last),
        .o_load_ready(load_ready), .o_load_done(load_done),
        .o_load_error(load_error), .o_busy(busy),
        .i_fetch_en(fetch_en), .i_stall(stall), .i_endereco(endereco),
        .o_instrucao(instrucao), .o_instr_valid(instr_valid), .o_addr_fault(addr_fault)
    );

    memoria_instrucoes_carregavel #(.DEPTH(8)) u_small (
        .i_clock(clk), .i_reset(rst),
        .i_load_start(s_load_start), .i_load_valid(s_load_valid),
        .i_load_data(s_load_data), .i_load_last(s_load_last),
        .o_load_ready(s_load_ready), .o_load_done(s_load_done),
        .o_load_error(s_load_error), .o_busy(s_busy),
        .i_fetch_en(s_fetch_en), .i_stall(s_stall), .i_endereco(s_endereco),
        .o_instrucao(s_instrucao), .o_instr_valid(s_instr_valid), .o_addr_fault(s_addr_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch-side cycle on the main instance while it is in RUN
    task automatic fetch(input logic en, input logic st, input logic [31:0] a, input string tag);
        exp_t e;
        exp_t got;
        if (st) begin
            e = last_e;
        end else if (en) begin
            e.v = 1'b1;
            e.f = (a >= 32'(D));
            e.d = (a >= 32'(D)) ? NOP : mdl[a[9:0]];
        end else begin
            e.v = 1'b0;
            e.f = 1'b0;
            e.d = last_e.d;
        end
        fetch_en = en;
        stall    = st;
        endereco = a;
        sb_q.push_back(e);
        tick();
        got = sb_q.pop_front();
        chk({tag, ".valid"}, 64'(instr_valid), 64'(got.v));
        chk({tag, ".fault"}, 64'(addr_fault), 64'(got.f));
        chk({tag, ".instr"}, 64'(instrucao), 64'(got.d));
        last_e   = got;
        fetch_en = 0;
        stall    = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input int idx, input logic last, input string tag);
        load_valid = 1;
        load_data  = d;
        load_last  = last;
        #1;
        chk({tag, ".ready"}, 64'(load_ready), 64'(1));
        tick();
        mdl[idx]   = d;
        load_valid = 0;
        load_last  = 0;
    endtask

    task automatic start_load(input string tag);
        load_start = 1;
        tick();
        load_start = 0;
        last_e = '{v: 1'b0, f: 1'b0, d: NOP};
        chk({tag, ".busy"}, 64'(busy), 64'(1));
    endtask

    initial begin
        last_e = '{v: 1'b0, f: 1'b0, d: NOP};

        // reset with a fetch request pending
        rst = 1; fetch_en = 1; endereco = 0;
        tick(); tick();
        chk("rst.valid", 64'(instr_valid), 64'(0));
        chk("rst.instr", 64'(instrucao), 64'(NOP));
        chk("rst.ready", 64'(load_ready), 64'(0));
        chk("rst.err",   64'(load_error), 64'(0));
        rst = 0;
        tick();
        chk("idle.valid", 64'(instr_valid), 64'(0));
        chk("idle.instr", 64'(instrucao), 64'(NOP));
        fetch_en = 0;

        // four-word program
        start_load("ld4");
        for (int i = 0; i < 4; i++) begin
            load_word(32'hA000_0001 + 32'(i), i, (i == 3), "ld4");
            chk("ld4.done", 64'(load_done), 64'(i == 3));
        end
        chk("ld4.busy", 64'(busy), 64'(0));
        chk("ld4.err",  64'(load_error), 64'(0));
        tick();
        chk("ld4.done_pulse", 64'(load_done), 64'(0));

        for (int a = 0; a < 4; a++)
            fetch(1, 0, 32'(a), "fetch");
        fetch(1, 0, 32'd1024, "oor1024");
        fetch(1, 0, 32'h8000_0002, "oor_nowrap");

        fetch(1, 0, 32'd2, "stall_req");
        fetch(1, 1, 32'd0, "stall1");
        fetch(1, 1, 32'd1, "stall2");
        fetch(0, 1, 32'd3, "stall3");
        fetch(0, 0, 32'd3, "idle_hold");
        fetch(1, 0, 32'd2000, "oor2000");
        fetch(0, 1, 32'd0, "stall_fault");

        // overflow on the DEPTH=8 instance
        s_load_start = 1;
        tick();
        s_load_start = 0;
        for (int i = 0; i < 9; i++) begin
            s_load_valid = 1;
            s_load_data  = 32'h5000_0000 + 32'(i);
            #1;
            chk("ovf.ready", 64'(s_load_ready), 64'(i < 8));
            tick();
            if (i == 7) begin
                chk("ovf.done", 64'(s_load_done), 64'(1));
                chk("ovf.err",  64'(s_load_error), 64'(1));
            end
        end
        s_load_valid = 0;
        chk("ovf.done_once", 64'(s_load_done), 64'(0));
        chk("ovf.err_sticky", 64'(s_load_error), 64'(1));
        s_fetch_en = 1; s_endereco = 7;
        tick();
        chk("ovf.word7", 64'(s_instrucao), 64'(32'h5000_0007));
        s_endereco = 8;
        tick();
        chk("ovf.f8.fault", 64'(s_addr_fault), 64'(1));
        chk("ovf.f8.instr", 64'(s_instrucao), 64'(NOP));
        s_fetch_en = 0;

        // load_start in RUN drops a pending fetch; restart mid-load
        fetch_en = 1; endereco = 0;
        start_load("rst_run");
        fetch_en = 0;
        chk("drop.valid", 64'(instr_valid), 64'(0));
        chk("drop.instr", 64'(instrucao), 64'(NOP));
        load_word(32'hB000_0001, 0, 0, "restart");
        load_word(32'hB000_0002, 1, 0, "restart");
        load_start = 1; load_valid = 1; load_data = 32'hDEAD_BEEF;
        #1;
        chk("restart.ready_on_start", 64'(load_ready), 64'(0));
        tick();
        load_start = 0; load_valid = 0;
        load_word(32'hC000_0001, 0, 0, "reload");
        load_word(32'hC000_0002, 1, 1, "reload");
        chk("reload.done", 64'(load_done), 64'(1));
        fetch(1, 0, 32'd0, "reload.f0");
        fetch(1, 0, 32'd1, "reload.f1");
        fetch(1, 0, 32'd2, "reload.f2");

        // reset in the middle of a load
        start_load("midrst");
        load_word(32'hE000_0001, 0, 0, "midrst");
        rst = 1;
        tick();
        rst = 0;
        chk("midrst.busy", 64'(busy), 64'(0));
        fetch_en = 1; endereco = 0;
        tick();
        chk("midrst.valid", 64'(instr_valid), 64'(0));
        chk("midrst.instr", 64'(instrucao), 64'(NOP));
        fetch_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
